// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16 x 16-bit register file.
package regfile_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam data_t REG_RST_VAL = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address-indexed mux over the register array.
// With REG_BYPASS_EN defined, a pending write to the same address is forwarded.
module regfile_read_port
  import regfile_pkg::*;
(
  input  data_t [NUM_REGS-1:0] regs_i,
  input  addr_t                addr_i,
`ifdef REG_BYPASS_EN
  input  logic                 byp_en_i,
  input  addr_t                byp_addr_i,
  input  data_t                byp_data_i,
`endif
  output data_t                data_o
);

  always_comb begin
    data_o = regs_i[addr_i];
`ifdef REG_BYPASS_EN
    if (byp_en_i && (byp_addr_i == addr_i)) begin
      data_o = byp_data_i;
    end
`endif
  end

endmodule

// File: rtl/register_file.sv
// 16 x 16-bit register file: two source read ports, one write port whose
// destination is steered by select, and a read port on that destination.
// Optional write-through forwarding is enabled by defining REG_BYPASS_EN.
module register_file
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd1,
  input  logic [ADDR_W-1:0] rd2,
  input  logic [DATA_W-1:0] writeData,
  input  logic              select,
  output logic [DATA_W-1:0] outR0,
  output logic [DATA_W-1:0] outR1,
  output logic [DATA_W-1:0] outR2
);

  data_t [NUM_REGS-1:0] regs_q, regs_d;
  addr_t                dest;

  assign dest = select ? rd1 : rd2;

  always_comb begin
    regs_d = regs_q;
    if (regWrite) begin
      regs_d[dest] = writeData;
    end
  end

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= {NUM_REGS{REG_RST_VAL}};
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REG_BYPASS_EN
  logic byp_en;
  assign byp_en = regWrite && !reset;
`endif

  regfile_read_port u_port_rs (
    .regs_i     (regs_q),
    .addr_i     (rs),
`ifdef REG_BYPASS_EN
    .byp_en_i   (byp_en),
    .byp_addr_i (dest),
    .byp_data_i (writeData),
`endif
    .data_o     (outR0)
  );

  regfile_read_port u_port_rt (
    .regs_i     (regs_q),
    .addr_i     (rt),
`ifdef REG_BYPASS_EN
    .byp_en_i   (byp_en),
    .byp_addr_i (dest),
    .byp_data_i (writeData),
`endif
    .data_o     (outR1)
  );

  regfile_read_port u_port_dest (
    .regs_i     (regs_q),
    .addr_i     (dest),
`ifdef REG_BYPASS_EN
    .byp_en_i   (byp_en),
    .byp_addr_i (dest),
    .byp_data_i (writeData),
`endif
    .data_o     (outR2)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read values
// from an array model; a negedge monitor pops and compares.
module tb_register_file;
  import regfile_pkg::*;

  logic  clk = 1'b0;
  logic  reset, regWrite, select;
  addr_t rs, rt, rd1, rd2;
  data_t writeData;
  data_t outR0, outR1, outR2;

  register_file dut (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .rs        (rs),
    .rt        (rt),
    .rd1       (rd1),
    .rd2       (rd2),
    .writeData (writeData),
    .select    (select),
    .outR0     (outR0),
    .outR1     (outR1),
    .outR2     (outR2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8*12-1:0] tag;
    data_t           r0;
    data_t           r1;
    data_t           r2;
  } exp_t;

  exp_t  q[$];
  data_t mem [NUM_REGS];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic data_t ref_read(input addr_t a, input logic rst, input logic we,
                                     input addr_t dst, input data_t wd);
    data_t v;
    v = mem[a];
`ifdef REG_BYPASS_EN
    if (we && !rst && (a == dst)) v = wd;
`endif
    return v;
  endfunction

  task automatic check(input logic [8*12-1:0] tag, input string port, input data_t got,
                       input data_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %0s %0s got %h want %h", tag, port, got, want);
  endtask

  // Monitor: outputs are sampled mid-cycle, after inputs settle, before the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check(e.tag, "outR0", outR0, e.r0);
        check(e.tag, "outR1", outR1, e.r1);
        check(e.tag, "outR2", outR2, e.r2);
      end
    end
  end

  task automatic step(input logic rst, input logic we, input logic sel, input addr_t a0,
                      input addr_t a1, input addr_t d1, input addr_t d2, input data_t wd,
                      input bit chk, input logic [8*12-1:0] tag);
    addr_t dst;
    exp_t  e;
    reset = rst; regWrite = we; select = sel;
    rs = a0; rt = a1; rd1 = d1; rd2 = d2; writeData = wd;
    dst = sel ? d1 : d2;
    if (chk) begin
      e.tag = tag;
      e.r0  = ref_read(a0, rst, we, dst, wd);
      e.r1  = ref_read(a1, rst, we, dst, wd);
      e.r2  = ref_read(dst, rst, we, dst, wd);
      q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
    end else if (we) begin
      mem[dst] = wd;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; regWrite = 1'b0; select = 1'b0;
    rs = '0; rt = '0; rd1 = '0; rd2 = '0; writeData = '0;
    @(posedge clk);
    #1;

    // Contents are unknown before the first reset edge, so nothing is checked there.
    step(1, 0, 0, 0, 1, 10, 2, 16'h0, 0, "reset");
    step(0, 0, 0, 0, 1, 10, 2, 16'h0, 1, "post_reset");
    step(0, 0, 1, 0, 1, 10, 2, 16'h0, 1, "post_reset");

    for (int k = 1; k <= 9; k += 2) begin
      step(0, 1, 1, 0, 1, addr_t'(k), 2, data_t'(k), 1, "wr_sel1");
      step(0, 0, 1, 0, 1, addr_t'(k), 2, 16'h0, 1, "rd_sel1");
    end
    for (int k = 2; k <= 10; k += 2) begin
      step(0, 1, 0, 0, 1, 1, addr_t'(k), data_t'(k), 1, "wr_sel0");
      step(0, 0, 0, 0, 1, 1, addr_t'(k), 16'h0, 1, "rd_sel0");
    end

    for (int i = 0; i < 3; i++) step(0, 0, 1, 3, 4, 6, 0, 16'h0, 1, "readback1");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 6, 7, 0, 9, 16'h0, 1, "readback0");
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, addr_t'(i), addr_t'(15 - i), addr_t'(i), 0, 16'h0, 1, "pre_sweep");

    step(1, 1, 1, 0, 0, 3, 0, 16'h1234, 1, "mid_reset");
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, addr_t'(i), addr_t'(15 - i), 0, addr_t'(i), 16'h0, 1, "zero_sweep");

    step(0, 1, 1, 0, 0, 5, 0, 16'h0005, 1, "wr5");
    step(0, 1, 1, 5, 5, 5, 0, 16'hBEEF, 1, "rdw");
    step(0, 0, 1, 5, 5, 5, 0, 16'h0, 1, "rdw_after");

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(39) == 0), 1'($urandom), 1'($urandom),
           addr_t'($urandom), addr_t'($urandom), addr_t'($urandom), addr_t'($urandom),
           data_t'($urandom), 1, "random");
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain queue_left got %0d want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
